// File: rtl/gamepad_reader.sv
// gamepad_reader: polls a Sega-style 6-button pad once per video frame.
// A rising edge on v_sync starts a poll of eight select phases. The sampled
// buttons are collected in a shadow register and committed in one step.
// Optional build macro GAMEPAD_DEBOUNCE_EN: the new buttons are committed
// only when two consecutive polls agree. A disconnect still clears the
// buttons at once.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | select held high, waiting for a v_sync rise
// POLL   | eight select phases of PHASE_CYCLES clocks, sampling the pad
// COMMIT | one clock: publish the shadow register and flags
`timescale 1ns/1ps
module gamepad_reader #(
    parameter int PHASE_CYCLES = 500,
    parameter int CNT_W        = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        v_sync,
    input  logic [5:0]  pad_data,
    output logic        pad_select,
    output logic [11:0] gamepad_input,
    output logic        pad_valid,
    output logic        pad_connected,
    output logic        pad_six_button
);

    typedef enum logic [1:0] {IDLE, POLL, COMMIT} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYCLES - 1);

    state_t           state, state_nxt;
    logic [5:0]       sync1, sync2;
    logic [5:0]       d;
    logic             vs_cur, vs_prev;
    logic             vs_rise;
    logic [2:0]       phase, phase_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [11:0]      shadow, shadow_nxt;
    logic             conn, conn_nxt;
    logic             six, six_nxt;
    logic             phase_end;

    // The pad pins are active-low; once synchronized the bench of logic works active-high.
    assign d         = ~sync2;
    assign vs_rise   = vs_cur & ~vs_prev;
    assign phase_end = (cnt == CNT_LAST);

    // Synchronize the pad pins and register v_sync for edge detection.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1   <= '0;
            sync2   <= '0;
            vs_cur  <= 1'b0;
            vs_prev <= 1'b0;
        end else begin
            sync1   <= pad_data;
            sync2   <= sync1;
            vs_cur  <= v_sync;
            vs_prev <= vs_cur;
        end
    end

    // FSM state, phase/cycle counters and the shadow register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state  <= IDLE;
            phase  <= '0;
            cnt    <= '0;
            shadow <= '0;
            conn   <= 1'b0;
            six    <= 1'b0;
        end else begin
            state  <= state_nxt;
            phase  <= phase_nxt;
            cnt    <= cnt_nxt;
            shadow <= shadow_nxt;
            conn   <= conn_nxt;
            six    <= six_nxt;
        end
    end

    // Next-state logic, select drive and sampling on the last cycle of each phase.
    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        cnt_nxt    = cnt;
        shadow_nxt = shadow;
        conn_nxt   = conn;
        six_nxt    = six;
        pad_select = 1'b1;
        case (state)
            IDLE: begin
                if (vs_rise) begin
                    state_nxt  = POLL;
                    phase_nxt  = '0;
                    cnt_nxt    = '0;
                    shadow_nxt = '0;
                    conn_nxt   = 1'b0;
                    six_nxt    = 1'b0;
                end
            end
            POLL: begin
                pad_select = ~phase[0];
                if (phase_end) begin
                    cnt_nxt = '0;
                    case (phase)
                        3'd0: begin
                            shadow_nxt[3:0] = d[3:0];
                            shadow_nxt[5]   = d[4];
                            shadow_nxt[6]   = d[5];
                        end
                        3'd1: begin
                            conn_nxt      = (d[3:2] == 2'b11);
                            shadow_nxt[4] = d[4];
                            shadow_nxt[7] = d[5];
                        end
                        3'd5: six_nxt = (d[3:0] == 4'b1111);
                        3'd6: begin
                            // Bit order in the shadow is X, Y, Z, Mode; the pad reports Z, Y, X, Mode.
                            shadow_nxt[11:8] = six ? {d[3], d[0], d[1], d[2]} : 4'h0;
                        end
                        default: ;
                    endcase
                    if (phase == 3'd7) begin
                        state_nxt = COMMIT;
                    end else begin
                        phase_nxt = phase + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef GAMEPAD_DEBOUNCE_EN
    logic [11:0] prev_shadow;

    // Commit only when two consecutive polls agree; a disconnect clears at once.
    always_ff @(posedge clock) begin
        if (!reset) begin
            gamepad_input  <= '0;
            pad_valid      <= 1'b0;
            pad_connected  <= 1'b0;
            pad_six_button <= 1'b0;
            prev_shadow    <= '0;
        end else begin
            pad_valid <= 1'b0;
            if (state == COMMIT) begin
                pad_connected  <= conn;
                pad_six_button <= conn & six;
                prev_shadow    <= shadow;
                if (!conn) begin
                    gamepad_input <= '0;
                    pad_valid     <= 1'b1;
                end else if (shadow == prev_shadow) begin
                    gamepad_input <= shadow;
                    pad_valid     <= 1'b1;
                end
            end
        end
    end
`else
    // Every completed poll is committed.
    always_ff @(posedge clock) begin
        if (!reset) begin
            gamepad_input  <= '0;
            pad_valid      <= 1'b0;
            pad_connected  <= 1'b0;
            pad_six_button <= 1'b0;
        end else begin
            pad_valid <= 1'b0;
            if (state == COMMIT) begin
                gamepad_input  <= conn ? shadow : 12'h000;
                pad_connected  <= conn;
                pad_six_button <= conn & six;
                pad_valid      <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gamepad_reader.sv
// Bench for gamepad_reader: a behavioural pad answers the select line, a
// scoreboard holds the expected commit of each poll, and a monitor checks
// every pad_valid pulse against it.
`timescale 1ns/1ps
module tb_gamepad_reader;

    localparam int P = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        v_sync = 1'b0;
    logic [5:0]  pad_data;
    logic        pad_select;
    logic [11:0] gamepad_input;
    logic        pad_valid;
    logic        pad_connected;
    logic        pad_six_button;

    gamepad_reader #(.PHASE_CYCLES(P), .CNT_W(3)) dut (
        .clock          (clock),
        .reset          (reset),
        .v_sync         (v_sync),
        .pad_data       (pad_data),
        .pad_select     (pad_select),
        .gamepad_input  (gamepad_input),
        .pad_valid      (pad_valid),
        .pad_connected  (pad_connected),
        .pad_six_button (pad_six_button)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [11:0] gp;
        logic        conn;
        logic        six;
        int          t0;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          fall_total = 0;
    int          fall_base  = 0;
    int          pad_kind   = 0;   // 0: nothing attached, 3: 3-button, 6: 6-button
    logic [11:0] pad_btn    = '0;
    logic [11:0] last_gp    = '0;
    logic [11:0] prev_shadow = '0;

    always @(posedge clock) cyc++;
    always @(negedge pad_select) fall_total++;

    // Pad device: answers according to select level and how many select pulses it has seen.
    function automatic logic [5:0] pad_pins(int kind, logic sel, int n, logic [11:0] b);
        logic [5:0] act;
        if (kind == 0)
            act = 6'h00;
        else if (sel)
            act = (kind == 6 && n == 3) ? {b[6], b[5], b[11], b[8], b[9], b[10]}
                                        : {b[6], b[5], b[3], b[2], b[1], b[0]};
        else
            act = (kind == 6 && n == 3) ? {b[7], b[4], 4'b1111}
                                        : {b[7], b[4], 2'b11, b[1], b[0]};
        return ~act;
    endfunction

    always_comb pad_data = pad_pins(pad_kind, pad_select, fall_total - fall_base, pad_btn);

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // What a poll of this pad should publish.
    function automatic exp_t predict(int kind, logic [11:0] b, int t0);
        exp_t e;
        e.t0 = t0;
        if (kind == 0) begin
            e.gp = 12'h000; e.conn = 1'b0; e.six = 1'b0;
        end else if (kind == 3) begin
            e.gp = b & 12'h0FF; e.conn = 1'b1; e.six = 1'b0;
        end else begin
            e.gp = b; e.conn = 1'b1; e.six = 1'b1;
        end
        return e;
    endfunction

    // Monitor: every pad_valid pulse must match the oldest expected commit.
    always @(negedge clock) begin
        exp_t e;
        if (pad_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: pad_valid=1 at cycle %0d, required no commit", cyc);
            end else begin
                e = sb.pop_front();
                check("gamepad_input", 32'(gamepad_input), 32'(e.gp));
                check("pad_connected", 32'(pad_connected), 32'(e.conn));
                check("pad_six_button", 32'(pad_six_button), 32'(e.six));
                check("valid_latency", 32'(cyc - e.t0), 32'(8 * P + 2));
            end
        end
    end

    // One frame: v_sync rise, optional extra rise in phase 3, optional reset in phase 4.
    task automatic run_poll(int kind, logic [11:0] b, bit mid_rise, bit abort);
        exp_t e;
        int   t0;
        int   i_mid;
        int   i_rst;
        bit   exp_sel;
        if (b[0] && b[1]) b[1] = 1'b0;
        i_mid = 2 + 3 * P + 1;
        i_rst = 2 + 4 * P + 1;
        @(negedge clock);
        pad_kind  = kind;
        pad_btn   = b;
        fall_base = fall_total;
        v_sync    = 1'b1;
        t0        = cyc + 1;
        e = predict(kind, b, t0);
        if (!abort) begin
`ifdef GAMEPAD_DEBOUNCE_EN
            if (!e.conn || e.gp == prev_shadow) begin
                sb.push_back(e);
                last_gp = e.gp;
            end
            prev_shadow = e.gp;
`else
            sb.push_back(e);
            last_gp = e.gp;
`endif
        end
        for (int i = 1; i <= 8 * P + 8; i++) begin
            @(negedge clock);
            if (abort && i > i_rst)
                exp_sel = 1'b1;
            else if (i >= 2 && i < 2 + 8 * P)
                exp_sel = (((i - 2) / P) % 2) == 0;
            else
                exp_sel = 1'b1;
            check("pad_select", 32'(pad_select), 32'(exp_sel));
            if (i == 4) v_sync = 1'b0;
            if (mid_rise && i == i_mid) v_sync = 1'b1;
            if (mid_rise && i == i_mid + 2) v_sync = 1'b0;
            if (abort && i == i_rst) reset = 1'b0;
            if (abort && i == i_rst + 2) begin
                reset = 1'b1;
                last_gp = '0;
                prev_shadow = '0;
            end
            if (abort && i == i_rst + 3) begin
                check("abort_gamepad_input", 32'(gamepad_input), 32'h0);
                check("abort_pad_connected", 32'(pad_connected), 32'h0);
                check("abort_pad_six_button", 32'(pad_six_button), 32'h0);
                check("abort_pad_valid", 32'(pad_valid), 32'h0);
            end
        end
        check("commit_seen", 32'(sb.size()), 32'h0);
        check("hold_gamepad_input", 32'(gamepad_input), 32'(last_gp));
    endtask

    initial begin
        int          kind;
        logic [11:0] b;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (10) @(negedge clock);
        check("reset_pad_select", 32'(pad_select), 32'h1);
        check("reset_gamepad_input", 32'(gamepad_input), 32'h0);
        check("reset_pad_valid", 32'(pad_valid), 32'h0);
        check("reset_pad_connected", 32'(pad_connected), 32'h0);
        check("reset_pad_six_button", 32'(pad_six_button), 32'h0);

        run_poll(6, 12'h410, 1'b0, 1'b0);
        run_poll(3, 12'h0C1, 1'b0, 1'b0);
        run_poll(0, 12'hFFF, 1'b0, 1'b0);
        run_poll(6, 12'h3A5, 1'b1, 1'b0);
        run_poll(3, 12'h0F6, 1'b0, 1'b1);
        run_poll(6, 12'h821, 1'b0, 1'b0);

        run_poll(6, 12'h008, 1'b0, 1'b0);
        run_poll(6, 12'h000, 1'b0, 1'b0);
        run_poll(6, 12'h008, 1'b0, 1'b0);
        run_poll(6, 12'h008, 1'b0, 1'b0);

        for (int n = 0; n < 10; n++) begin
            case ($urandom_range(0, 3))
                0:       kind = 0;
                1:       kind = 3;
                default: kind = 6;
            endcase
            b = 12'($urandom);
            run_poll(kind, b, 1'b0, 1'b0);
            if (kind != 0 && $urandom_range(0, 1) == 1)
                run_poll(kind, b, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gamepad_reader.md
Name: gamepad_reader

Overview:
- Reads one Sega-style 6-button pad through a 6-pin data bus plus a select line.
- Produces the 12-bit active-high button vector `gamepad_input` that the Map stage consumes.
- Runs one poll sequence per video frame, triggered by the rising edge of `v_sync`.
- Results are committed atomically at the end of each poll.

Parameters:
- PHASE_CYCLES, 500: clocks per select phase (10 us at 50 MHz); legal range ≥ 4.
- CNT_W, 10: width of the phase-cycle counter; must satisfy 2^CNT_W > PHASE_CYCLES.

Ports:
- clock  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-low reset
- v_sync  in  1  frame sync from the video timing; a rising edge starts a poll
- pad_data  in  6  raw pad pins, active-low, asynchronous: [0] Up, [1] Down, [2] Left, [3] Right, [4] B/A, [5] C/Start
- pad_select  out  1  select line driven to the pad
- gamepad_input  out  12  buttons, active-high: [0] Up, [1] Down, [2] Left, [3] Right, [4] A, [5] B, [6] C, [7] Start, [8] X, [9] Y, [10] Z, [11] Mode
- pad_valid  out  1  one-clock pulse when `gamepad_input` is updated
- pad_connected  out  1  pad detected on the last poll
- pad_six_button  out  1  6-button ID seen on the last poll

Behaviour:
- **Reset:** clock and reset are as already decided — one clock; reset is synchronous and active-low. While reset=0 at a clock edge:
  - state=IDLE, pad_select=1, gamepad_input=0, pad_valid=0, pad_connected=0, pad_six_button=0;
  - counters, synchronizers, the v_sync edge register and the shadow register clear;
  - reset mid-poll abandons the poll and does not commit.
- **Input conditioning:**
  - pad_data passes through a 2-flop synchronizer, then is inverted to active-high d[5:0].
  - v_sync is registered once; a rise is prev=0, cur=1.
- **FSM states:** IDLE, POLL, COMMIT.
- **IDLE:**
  - pad_select=1.
  - A v_sync rise moves to POLL with phase=0 and cnt=0.
- **POLL:**
  - phase runs 0..7; pad_select = ~phase[0], so phases 0, 2, 4, 6 are high and 1, 3, 5, 7 are low.
  - cnt counts 0..PHASE_CYCLES-1.
  - d is sampled into a shadow register on the cycle cnt==PHASE_CYCLES-1; that cycle then advances phase and resets cnt.
- **Samples:**
  - phase 0: Up, Down, Left, Right, B, C = d[0..5].
  - phase 1: connected = (d[3:2]==2'b11) i.e. pins low; A=d[4]; Start=d[5].
  - phase 5: six = (d[3:0]==4'b1111).
  - phase 6: only if six, Z=d[0], Y=d[1], X=d[2], Mode=d[3]; otherwise X, Y, Z, Mode = 0.
  - phases 2, 3, 4, 7: drive select only; no sampling.
- **End of poll:** after phase 7's last cycle, go to COMMIT.
- **COMMIT (1 cycle):**
  - gamepad_input = connected ? shadow : 12'h000;
  - pad_connected = connected; pad_six_button = connected & six;
  - pad_valid=1 for this cycle only; next state IDLE.
- **Latency:** the v_sync rise is registered, so IDLE sees it one clock after v_sync first reads high and POLL begins the following clock. POLL lasts 8×PHASE_CYCLES clocks; COMMIT adds 1; so pad_valid rises 8×PHASE_CYCLES+2 clocks after v_sync first reads high.
- **Boundary conditions:**
  - v_sync rises during POLL or COMMIT are ignored, not queued.
  - gamepad_input holds its value between commits.
  - Simultaneous reset and v_sync rise: reset wins.
  - A 3-button pad (phase 5 d[3:0] not all 1) gives six=0 with X, Y, Z, Mode=0; the other buttons are valid.
  - Disconnected pad (pins pulled high, so d=0): connected=0 and outputs are zeroed.

Optional Feature:
- Macro: GAMEPAD_DEBOUNCE_EN.
- **Defined:** a second register keeps the previous poll's shadow. In COMMIT, gamepad_input updates only when the current shadow equals the previous one, i.e. two consecutive matching polls. pad_valid pulses only when the update happens. pad_connected and pad_six_button still update every poll. A disconnect (connected=0) zeroes gamepad_input immediately, without waiting for a second poll.
- **Not defined:** every poll commits, as described above.

Test Plan (PHASE_CYCLES=4):
- Reset low for 3 clocks, then release with no v_sync -> pad_select=1, gamepad_input=0, pad_valid never pulses.
- 6-button pad model, A and Z held, v_sync rise -> select toggles 1,0,1,0,1,0,1,0 at 4 clocks each; pad_valid pulses 34 clocks after v_sync first reads high; gamepad_input=12'h410; pad_six_button=1; pad_connected=1.
- 3-button pad model, Up, C and Start held -> gamepad_input=12'h0C1, pad_six_button=0.
- pad_data=6'h3F (nothing attached) -> gamepad_input=0, pad_connected=0, pad_valid pulses.
- Second v_sync rise during phase 3, then reset asserted during phase 4 of the next poll -> the mid-poll rise starts nothing; after reset, pad_select=1 and outputs are 0 with no commit; the next v_sync rise polls normally.
- GAMEPAD_DEBOUNCE_EN defined: Right held for one frame, then released -> no update and no pad_valid after frame 1; Right held for two frames -> gamepad_input=12'h008 after frame 2.
